// File: rtl/dwrr_input_queues.sv
// dwrr_input_queues: per-requestor packet FIFOs that feed a DWRR arbiter and pop the granted queue.
//   clk, rst    clock and asynchronous active-high reset
//   push        per-queue write strobe; push_data slice i is the payload for queue i
//   full, reqs  per-queue full / non-empty status (reqs drives the arbiter request vector)
//   gnt         arbiter grant, expected one-hot or zero
//   out_valid   a dequeued packet is on out_data / out_id this cycle
//   ovf         sticky per-queue "push dropped because full"
//   gnt_err     sticky "grant was multi-hot or selected an empty queue"
module dwrr_input_queues #(
    parameter int NUM_REQS = 4,
    parameter int DWID     = 8,
    parameter int DEPTH    = 4,
    parameter int PTRWID   = $clog2(DEPTH),
    parameter int CNTWID   = $clog2(NUM_REQS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQS-1:0]      push,
    input  logic [NUM_REQS*DWID-1:0] push_data,
    output logic [NUM_REQS-1:0]      full,
    output logic [NUM_REQS-1:0]      reqs,
    input  logic [NUM_REQS-1:0]      gnt,
    output logic                     out_valid,
    output logic [DWID-1:0]          out_data,
    output logic [CNTWID-1:0]        out_id,
    output logic [NUM_REQS-1:0]      ovf,
    output logic                     gnt_err
);
    localparam logic [PTRWID:0] FULL_CNT = (PTRWID+1)'(DEPTH);

    logic [DWID-1:0]     mem [NUM_REQS][DEPTH];
    logic [PTRWID-1:0]   wptr [NUM_REQS];
    logic [PTRWID-1:0]   rptr [NUM_REQS];
    logic [PTRWID:0]     cnt [NUM_REQS];
    logic                one_hot;
    logic                err;
    logic [NUM_REQS-1:0] wr;
    logic [NUM_REQS-1:0] pop;
    logic [CNTWID-1:0]   idx;
    logic [DWID-1:0]     rd_data;

    always_comb begin
        full = '0;
        reqs = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            full[i] = cnt[i] == FULL_CNT;
            reqs[i] = cnt[i] != '0;
        end
    end

    assign one_hot = (gnt != '0) && ((gnt & (gnt - NUM_REQS'(1))) == '0);
    // A pop needs a one-hot grant landing on a non-empty queue; anything else pops nothing.
    assign pop     = one_hot ? (gnt & reqs) : '0;
    assign err     = (gnt != '0) && (!one_hot || (gnt & ~reqs) != '0);
    // Fullness comes from the registered count, so a same-cycle pop never makes room.
    assign wr      = push & ~full;

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_REQS; i++)
            if (pop[i]) idx = CNTWID'(i);
    end

    assign rd_data = mem[idx][rptr[idx]];

    // Payload storage carries no reset; only pointers and counts define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQS; i++)
            if (wr[i]) mem[i][wptr[i]] <= push_data[i*DWID +: DWID];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            ovf       <= '0;
            gnt_err   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (wr[i]) wptr[i] <= wptr[i] + PTRWID'(1);
                if (pop[i]) rptr[i] <= rptr[i] + PTRWID'(1);
                cnt[i] <= cnt[i] + (PTRWID+1)'(wr[i]) - (PTRWID+1)'(pop[i]);
            end
            out_valid <= |pop;
            if (|pop) begin
                out_data <= rd_data;
                out_id   <= idx;
            end
            ovf     <= ovf | (push & full);
            gnt_err <= gnt_err | err;
        end
    end
endmodule
